// File: rtl/alu_ctl_seq.sv
// alu_ctl_seq: ALU control decoder with a handshaked output sequencer.
// A request is decoded into a 4-bit ALU control code and emitted as either
// one beat (non-shift ops, illegal ops, zero-amount shifts) or as a train of
// shift-by-1 beats, one per unit of the shift amount.
module alu_ctl_seq #(
  parameter int SHAMT_W    = 5,
  parameter int ENABLE_SRA = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUop,
  input  logic [5:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         ALUctr,
  output logic               shift_step,
  output logic               out_last,
  output logic               illegal,
  output logic               busy
);

  // ALU control codes
  localparam logic [3:0] CTR_AND = 4'b0000;
  localparam logic [3:0] CTR_OR  = 4'b0001;
  localparam logic [3:0] CTR_ADD = 4'b0010;
  localparam logic [3:0] CTR_SUB = 4'b0110;
  localparam logic [3:0] CTR_SLT = 4'b0111;
  localparam logic [3:0] CTR_SLL = 4'b1000;
  localparam logic [3:0] CTR_SRL = 4'b1001;
  localparam logic [3:0] CTR_SRA = 4'b1010;
  localparam logic [3:0] CTR_ILL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EMIT  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t               state, state_d;
  logic [SHAMT_W-1:0]   remaining, remaining_d;
  logic [3:0]           ctr_q, ctr_d;
  logic                 ill_q, ill_d;

  logic [3:0]           dec_code;
  logic                 dec_ill;
  logic                 dec_shift;
  logic                 accept_in;
  logic                 accept_out;
  logic                 last_shift;

  // Combinational decode of the request fields (only consumed at acceptance)
  always_comb begin
    dec_code  = CTR_ILL;
    dec_ill   = 1'b1;
    dec_shift = 1'b0;
    case (ALUop)
      2'b00: begin
        dec_code = CTR_ADD;
        dec_ill  = 1'b0;
      end
      2'b01: begin
        dec_code = CTR_SUB;
        dec_ill  = 1'b0;
      end
      2'b10: begin
        case (func)
          6'b100000, 6'b100001: begin
            dec_code = CTR_ADD;
            dec_ill  = 1'b0;
          end
          6'b100010, 6'b100011: begin
            dec_code = CTR_SUB;
            dec_ill  = 1'b0;
          end
          6'b101010, 6'b101011: begin
            dec_code = CTR_SLT;
            dec_ill  = 1'b0;
          end
          6'b100101: begin
            dec_code = CTR_OR;
            dec_ill  = 1'b0;
          end
          6'b100100: begin
            dec_code = CTR_AND;
            dec_ill  = 1'b0;
          end
          6'b000000: begin
            dec_code  = CTR_SLL;
            dec_ill   = 1'b0;
            dec_shift = 1'b1;
          end
          6'b000010: begin
            dec_code  = CTR_SRL;
            dec_ill   = 1'b0;
            dec_shift = 1'b1;
          end
          6'b000011: begin
            if (ENABLE_SRA != 0) begin
              dec_code  = CTR_SRA;
              dec_ill   = 1'b0;
              dec_shift = 1'b1;
            end
          end
          default: begin
            dec_code = CTR_ILL;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code = CTR_ILL;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign accept_in  = in_valid && (state == IDLE);
  assign accept_out = out_ready && (state != IDLE);
  assign last_shift = (remaining == SHAMT_W'(1));

  // Next-state, remaining-count and beat-content logic
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    ctr_d       = ctr_q;
    ill_d       = ill_q;
    case (state)
      IDLE: begin
        if (accept_in) begin
          ctr_d = dec_code;
          ill_d = dec_ill;
          if (dec_shift && (shamt != '0)) begin
            state_d     = SHIFT;
            remaining_d = shamt;
          end else begin
            state_d     = EMIT;
            remaining_d = '0;
          end
        end
      end
      EMIT: begin
        if (accept_out) begin
          state_d = IDLE;
          ctr_d   = '0;
          ill_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (accept_out) begin
          if (last_shift) begin
            state_d     = IDLE;
            remaining_d = '0;
            ctr_d       = '0;
            ill_d       = 1'b0;
          end else begin
            remaining_d = remaining - SHAMT_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
        ctr_d       = '0;
        ill_d       = 1'b0;
      end
    endcase
  end

  // State and beat registers; synchronous reset wins over every handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      ctr_q     <= '0;
      ill_q     <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      ctr_q     <= ctr_d;
      ill_q     <= ill_d;
    end
  end

  // Outputs depend only on registered state, never directly on input fields
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state != IDLE);
  assign ALUctr     = ctr_q;
  assign illegal    = ill_q;
  assign shift_step = (state == SHIFT);
  assign out_last   = (state == EMIT) || ((state == SHIFT) && last_shift);

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Directed testbench for alu_ctl_seq. Inputs are driven on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_alu_ctl_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUop;
  logic [5:0] func;
  logic [4:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALUctr;
  logic       shift_step;
  logic       out_last;
  logic       illegal;
  logic       busy;

  // second instance with sra decode disabled, sharing all inputs
  logic       n_in_ready;
  logic       n_out_valid;
  logic [3:0] n_alu_ctr;
  logic       n_shift_step;
  logic       n_out_last;
  logic       n_illegal;
  logic       n_busy;

  int unsigned n_checks;
  int unsigned n_errors;

  alu_ctl_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .func       (func),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUctr     (ALUctr),
    .shift_step (shift_step),
    .out_last   (out_last),
    .illegal    (illegal),
    .busy       (busy)
  );

  alu_ctl_seq #(.SHAMT_W(5), .ENABLE_SRA(0)) dut_nosra (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (n_in_ready),
    .ALUop      (ALUop),
    .func       (func),
    .shamt      (shamt),
    .out_valid  (n_out_valid),
    .out_ready  (out_ready),
    .ALUctr     (n_alu_ctr),
    .shift_step (n_shift_step),
    .out_last   (n_out_last),
    .illegal    (n_illegal),
    .busy       (n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present a request for one cycle, then scramble the fields so any late
  // sampling shows up. Starts and ends on a falling edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sa);
    in_valid = 1'b1;
    ALUop    = op;
    func     = fn;
    shamt    = sa;
    @(negedge clk);
    in_valid = 1'b0;
    ALUop    = 2'b11;
    func     = 6'b111111;
    shamt    = 5'($urandom_range(0, 31));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check_val({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  // Expect n consecutive beats with out_ready=1, then an idle cycle.
  task automatic collect(input string tag, input logic [3:0] ctr, input logic sh,
                         input logic ill, input int unsigned n);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      check_val({tag, ".out_valid"},  32'(out_valid),  32'd1);
      check_val({tag, ".ALUctr"},     32'(ALUctr),     32'(ctr));
      check_val({tag, ".shift_step"}, 32'(shift_step), 32'(sh));
      check_val({tag, ".illegal"},    32'(illegal),    32'(ill));
      check_val({tag, ".out_last"},   32'(out_last),   32'(i == n - 1));
      check_val({tag, ".in_ready"},   32'(in_ready),   32'd0);
      check_val({tag, ".busy"},       32'(busy),       32'd1);
      @(negedge clk);
    end
    check_idle({tag, ".end"});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;   // coincident with reset: must be ignored
    ALUop     = 2'b10;
    func      = 6'b000000;
    shamt     = 5'd7;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check_val("rst.out_valid",  32'(out_valid),  32'd0);
    check_val("rst.ALUctr",     32'(ALUctr),     32'd0);
    check_val("rst.shift_step", 32'(shift_step), 32'd0);
    check_val("rst.out_last",   32'(out_last),   32'd0);
    check_val("rst.illegal",    32'(illegal),    32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    check_val("post_rst.ALUctr", 32'(ALUctr), 32'd0);

    // single-beat R-type and I-type ops
    send(2'b10, 6'b100010, 5'd9); collect("sub",  4'b0110, 1'b0, 1'b0, 1);
    send(2'b00, 6'b000000, 5'd3); collect("iadd", 4'b0010, 1'b0, 1'b0, 1);
    send(2'b01, 6'b000010, 5'd3); collect("isub", 4'b0110, 1'b0, 1'b0, 1);
    send(2'b10, 6'b100000, 5'd0); collect("add",  4'b0010, 1'b0, 1'b0, 1);
    send(2'b10, 6'b100001, 5'd0); collect("addu", 4'b0010, 1'b0, 1'b0, 1);
    send(2'b10, 6'b100011, 5'd0); collect("subu", 4'b0110, 1'b0, 1'b0, 1);
    send(2'b10, 6'b101010, 5'd0); collect("slt",  4'b0111, 1'b0, 1'b0, 1);
    send(2'b10, 6'b101011, 5'd0); collect("sltu", 4'b0111, 1'b0, 1'b0, 1);
    send(2'b10, 6'b100101, 5'd0); collect("or",   4'b0001, 1'b0, 1'b0, 1);
    send(2'b10, 6'b100100, 5'd0); collect("and",  4'b0000, 1'b0, 1'b0, 1);

    // multi-beat shifts
    send(2'b10, 6'b000000, 5'd3); collect("sll3", 4'b1000, 1'b1, 1'b0, 3);
    send(2'b10, 6'b000011, 5'd2); collect("sra2", 4'b1010, 1'b1, 1'b0, 2);

    // srl by 4 with beat 2 stalled for two cycles
    send(2'b10, 6'b000010, 5'd4);
    check_val("srl.b1.ALUctr",   32'(ALUctr),   32'd9);
    check_val("srl.b1.out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      check_val("srl.hold.out_valid",  32'(out_valid),  32'd1);
      check_val("srl.hold.ALUctr",     32'(ALUctr),     32'd9);
      check_val("srl.hold.shift_step", 32'(shift_step), 32'd1);
      check_val("srl.hold.out_last",   32'(out_last),   32'd0);
      check_val("srl.hold.illegal",    32'(illegal),    32'd0);
      if (k < 2) @(negedge clk);
    end
    collect("srl.rest", 4'b1001, 1'b1, 1'b0, 3);

    // illegal requests
    send(2'b10, 6'b111111, 5'd4); collect("ill_func", 4'b1111, 1'b0, 1'b1, 1);
    send(2'b11, 6'b100000, 5'd0); collect("ill_op",   4'b1111, 1'b0, 1'b1, 1);
    send(2'b10, 6'b000011, 5'd0);
    check_val("nosra.out_valid",  32'(n_out_valid),  32'd1);
    check_val("nosra.ALUctr",     32'(n_alu_ctr),    32'hF);
    check_val("nosra.illegal",    32'(n_illegal),    32'd1);
    check_val("nosra.out_last",   32'(n_out_last),   32'd1);
    check_val("nosra.shift_step", 32'(n_shift_step), 32'd0);
    check_val("nosra.busy",       32'(n_busy),       32'd1);
    collect("sra0", 4'b1010, 1'b0, 1'b0, 1);
    check_val("nosra.in_ready",   32'(n_in_ready),   32'd1);

    // sra with shamt>0 under ENABLE_SRA=0 is still a single illegal beat
    send(2'b10, 6'b000011, 5'd3);
    check_val("nosra3.ALUctr",   32'(n_alu_ctr),  32'hF);
    check_val("nosra3.out_last", 32'(n_out_last), 32'd1);
    collect("sra3", 4'b1010, 1'b1, 1'b0, 3);

    // reset in the middle of a shift, with the beat held
    send(2'b10, 6'b000000, 5'd5);
    check_val("rst_mid.b1.ALUctr", 32'(ALUctr), 32'd8);
    @(negedge clk);
    check_val("rst_mid.b2.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    ALUop     = 2'b10;
    func      = 6'b100010;
    @(negedge clk);
    check_idle("rst_mid");
    check_val("rst_mid.ALUctr",     32'(ALUctr),     32'd0);
    check_val("rst_mid.shift_step", 32'(shift_step), 32'd0);
    check_val("rst_mid.out_last",   32'(out_last),   32'd0);
    check_val("rst_mid.illegal",    32'(illegal),    32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("rst_mid.after");
    @(negedge clk);
    check_idle("rst_mid.after2");

    // shift amount boundaries
    send(2'b10, 6'b000000, 5'd0);  collect("sll0",  4'b1000, 1'b0, 1'b0, 1);
    send(2'b10, 6'b000000, 5'd31); collect("sll31", 4'b1000, 1'b1, 1'b0, 31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_ctl_seq.md
ALU_CTL_SEQ -- requirements
Module: alu_ctl_seq

Interface
REQ-001 Parameter SHAMT_W, default 5, is the shift-amount width.
REQ-002 Parameter ENABLE_SRA, default 1, enables decode of sra; when 0, sra is illegal.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on ALUop/func/shamt.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 ALUop  input  2  main-control op class: 00 I-add, 01 I-sub, 10 R-type, 11 reserved.
REQ-008 func  input  6  instruction function field.
REQ-009 shamt  input  SHAMT_W  shift amount.
REQ-010 out_valid  output  1  output beat present.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 ALUctr  output  4  ALU control code for the beat.
REQ-013 shift_step  output  1  beat is one shift-by-1 step.
REQ-014 out_last  output  1  final beat of the request.
REQ-015 illegal  output  1  request decoded as unsupported.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 Decode: ALUop 00 -> 0010; ALUop 01 -> 0110; ALUop 11 -> illegal.
REQ-018 ALUop 10 decode by func: 100000/100001 -> 0010; 100010/100011 -> 0110; 101010/101011 -> 0111; 100101 -> 0001; 100100 -> 0000; 000000 (sll) -> 1000; 000010 (srl) -> 1001; 000011 (sra, ENABLE_SRA=1) -> 1010.
REQ-019 Any other func, or any illegal case, gives ALUctr=1111 and illegal=1 on a single beat, with shift_step=0 and out_last=1.
REQ-020 States: IDLE, EMIT, SHIFT.
REQ-021 in_ready = 1 only in IDLE.
REQ-022 A request is accepted when in_valid & in_ready.
REQ-023 ALUop, func and shamt are sampled only at acceptance and are ignored at all other times.
REQ-024 Latency: acceptance at edge T gives out_valid=1 in the cycle after T; there is no combinational path from the input fields to the outputs.
REQ-025 A non-shift request, or a shift request with shamt=0, moves IDLE -> EMIT.
REQ-026 EMIT drives one beat: out_last=1, shift_step=0, and the decoded ALUctr (for shamt=0 shifts, the shift code).
REQ-027 A shift request with shamt=N>0 moves IDLE -> SHIFT and loads remaining=N.
REQ-028 SHIFT emits exactly N beats, each with the shift code and shift_step=1.
REQ-029 In SHIFT, remaining decrements by 1 per accepted beat, and out_last=1 when remaining=1.
REQ-030 shamt at its maximum value (2^SHAMT_W-1) gives exactly that many beats, with no wrap of remaining.
REQ-031 A beat is accepted when out_valid & out_ready; while out_ready=0, ALUctr, shift_step, out_last, illegal and remaining hold stable.
REQ-032 When the last beat is accepted, the next state is IDLE, so in_ready=1 the following cycle.
REQ-033 There is no back-to-back overlap: the minimum request period is beats+1 cycles.
REQ-034 busy = (state != IDLE).

Reset
REQ-035 While rst=1 at an edge: state=IDLE, remaining=0, out_valid=0, ALUctr=0000, shift_step=0, out_last=0, illegal=0.
REQ-036 After the reset edge, in_ready=1 and busy=0.
REQ-037 rst has priority over every handshake, including mid-SHIFT and while an output beat is held.
REQ-038 A request in progress at reset is discarded, with no further beats.
REQ-039 in_valid coincident with rst is not accepted.

Verification
REQ-040 ALUop=10, func=100010, out_ready=1 -> next cycle: out_valid=1, ALUctr=0110, out_last=1, shift_step=0; in_ready=1 the cycle after.
REQ-041 sll with shamt=3, out_ready=1 -> 3 consecutive beats ALUctr=1000, shift_step=1, out_last only on beat 3; in_ready stays 0 throughout, then returns to 1.
REQ-042 srl with shamt=4, out_ready=0 for 2 cycles at beat 2 -> beat 2 held unchanged, 4 beats total, out_last on beat 4.
REQ-043 ALUop=10, func=111111 -> one beat ALUctr=1111, illegal=1, out_last=1; repeat with ALUop=11 and with sra under ENABLE_SRA=0 -> same.
REQ-044 sll with shamt=5, rst asserted during beat 2 -> next cycle out_valid=0, busy=0, in_ready=1, all outputs 0.
REQ-045 sll with shamt=0 -> one beat ALUctr=1000, shift_step=0, out_last=1; shamt=31 (SHAMT_W=5) -> 31 beats.
